// File: rtl/tri_cnt_pkg.sv
// Shared types for the triangular wave counter:
// FSM state encoding and runtime mode codes.
package tri_cnt_pkg;

  typedef enum logic [1:0] {
    S_UP   = 2'd0,
    S_DOWN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_TRI     = 2'b00;
  localparam logic [1:0] MODE_SAW     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

endpackage

// File: rtl/tri_step_clamp.sv
// Saturating one-step up/down move of the count,
// clamped to [MIN_VAL, MAX_VAL] with a hit-limit flag.
module tri_step_clamp #(
  parameter int WIDTH   = 8,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 5,
  parameter int STEP    = 1
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             hit_o
);

  localparam logic [WIDTH:0] LO = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] HI = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] ST = (WIDTH+1)'(STEP);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] res;
  logic           sat;

  assign ext = {1'b0, cnt_i};

  // Distance-to-limit compare avoids any wrap of ext +/- ST.
  always_comb begin
    if (up_i) begin
      sat = (ext >= HI) || ((HI - ext) <= ST);
      res = sat ? HI : ext + ST;
    end else begin
      sat = (ext <= LO) || ((ext - LO) <= ST);
      res = sat ? LO : ext - ST;
    end
  end

  assign nxt_o = res[WIDTH-1:0];
  assign hit_o = sat;

endmodule

// File: rtl/tri_wave_counter.sv
// Triangle / sawtooth / one-shot count generator with peak/trough pulses.
// Optional period counter on trough pulses: define TRI_PERIOD_CNT_EN.
import tri_cnt_pkg::*;

module tri_wave_counter #(
  parameter int WIDTH   = 8,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 5,
  parameter int STEP    = 1,
  parameter int PCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic [1:0]        mode,
  input  logic              restart,
  output logic [WIDTH-1:0]  count,
  output logic              dir_up,
  output logic              peak,
  output logic              trough,
`ifdef TRI_PERIOD_CNT_EN
  output logic [PCNT_W-1:0] period_cnt,
`endif
  output logic              done
);

  localparam logic [WIDTH-1:0] MINW = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAX_VAL);

  generate
    if (MIN_VAL >= MAX_VAL || STEP < 1 || PCNT_W < 1 ||
        MAX_VAL >= (2 ** WIDTH)) begin : g_bad_cfg
      $error("tri_wave_counter: illegal parameter set");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             peak_q, peak_d;
  logic             trough_q, trough_d;
  logic             done_q, done_d;

  logic             saw;
  logic             oneshot;
  logic             step_up;
  logic [WIDTH-1:0] step_nxt;
  logic             step_hit;

  assign saw     = (mode == MODE_SAW);
  assign oneshot = (mode == MODE_ONESHOT);
  assign step_up = (state_q == S_UP) && (count_q < MAXW);

  tri_step_clamp #(
    .WIDTH   (WIDTH),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL),
    .STEP    (STEP)
  ) u_clamp (
    .cnt_i (count_q),
    .up_i  (step_up),
    .nxt_o (step_nxt),
    .hit_o (step_hit)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    peak_d   = 1'b0;
    trough_d = 1'b0;
    done_d   = done_q;
    if (restart) begin
      state_d = S_UP;
      count_d = MINW;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_UP: begin
          if (in) begin
            if (saw && !step_up) begin
              count_d  = MINW;
              trough_d = 1'b1;
            end else if (step_up) begin
              count_d = step_nxt;
              peak_d  = step_hit;
              if (step_hit && !saw)
                state_d = S_DOWN;
            end else begin
              // Parked at MAX after a saw->triangle switch: turn down.
              count_d  = step_nxt;
              trough_d = step_hit;
              state_d  = S_DOWN;
              if (step_hit) begin
                state_d = oneshot ? S_DONE : S_UP;
                done_d  = oneshot;
              end
            end
          end
        end
        S_DOWN: begin
          if (in) begin
            if (saw) begin
              count_d  = MINW;
              trough_d = 1'b1;
              state_d  = S_UP;
            end else begin
              count_d  = step_nxt;
              trough_d = step_hit;
              if (step_hit) begin
                state_d = oneshot ? S_DONE : S_UP;
                done_d  = oneshot;
              end
            end
          end
        end
        S_DONE: begin
          count_d = MINW;
        end
        default: begin
          state_d = S_UP;
          count_d = MINW;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_UP;
      count_q  <= MINW;
      peak_q   <= 1'b0;
      trough_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
      done_q   <= done_d;
    end
  end

`ifdef TRI_PERIOD_CNT_EN
  logic [PCNT_W-1:0] pcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pcnt_q <= '0;
    else if (trough_d)
      pcnt_q <= pcnt_q + 1'b1;
  end

  assign period_cnt = pcnt_q;
`endif

  assign count  = count_q;
  assign dir_up = (state_q == S_UP);
  assign peak   = peak_q;
  assign trough = trough_q;
  assign done   = done_q;

endmodule

// File: tb/tb_tri_wave_counter.sv
// Directed bench for tri_wave_counter: default build plus a STEP=2 copy
// sharing the same stimulus.
module tb_tri_wave_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_s = 1'b0;
  logic [1:0] mode_s = 2'b00;
  logic       restart_s = 1'b0;

  logic [7:0] cnt0, cnt2;
  logic       dir0, pk0, tr0, dn0;
  logic       dir2, pk2, tr2, dn2;
`ifdef TRI_PERIOD_CNT_EN
  logic [15:0] pc0, pc2;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tri_wave_counter u0 (
    .clk        (clk),
    .rst        (rst),
    .in         (in_s),
    .mode       (mode_s),
    .restart    (restart_s),
    .count      (cnt0),
    .dir_up     (dir0),
    .peak       (pk0),
    .trough     (tr0),
`ifdef TRI_PERIOD_CNT_EN
    .period_cnt (pc0),
`endif
    .done       (dn0)
  );

  tri_wave_counter #(.STEP(2)) u2 (
    .clk        (clk),
    .rst        (rst),
    .in         (in_s),
    .mode       (mode_s),
    .restart    (restart_s),
    .count      (cnt2),
    .dir_up     (dir2),
    .peak       (pk2),
    .trough     (tr2),
`ifdef TRI_PERIOD_CNT_EN
    .period_cnt (pc2),
`endif
    .done       (dn2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input logic i);
    in_s = i;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_s = 1'b0;
    restart_s = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int t1_cnt[11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
  int t1_pk[11]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  int t1_tr[11]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int t1_dir[11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
  int t2_cnt[7]  = '{2, 4, 5, 3, 1, 0, 2};
  int t2_pk[7]   = '{0, 0, 1, 0, 0, 0, 0};
  int t2_tr[7]   = '{0, 0, 0, 0, 0, 1, 0};
  int t3_cnt[10] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
  int t4_cnt[7]  = '{1, 2, 3, 4, 5, 0, 1};
  int t4_pk[7]   = '{0, 0, 0, 0, 1, 0, 0};
  int t4_tr[7]   = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    #2;
    check("rst_count", cnt0, 0);
    check("rst_dir", dir0, 1);
    check("rst_peak", pk0, 0);
    check("rst_trough", tr0, 0);
    check("rst_done", dn0, 0);
`ifdef TRI_PERIOD_CNT_EN
    check("rst_pcnt", pc0, 0);
`endif
    do_reset();

    // triangle, STEP=1 on u0 and STEP=2 on u2
    mode_s = 2'b00;
    for (int k = 0; k < 11; k++) begin
      adv(1'b1);
      check($sformatf("tri_cnt%0d", k), cnt0, t1_cnt[k]);
      check($sformatf("tri_pk%0d", k), pk0, t1_pk[k]);
      check($sformatf("tri_tr%0d", k), tr0, t1_tr[k]);
      check($sformatf("tri_dir%0d", k), dir0, t1_dir[k]);
      if (k < 7) begin
        check($sformatf("s2_cnt%0d", k), cnt2, t2_cnt[k]);
        check($sformatf("s2_pk%0d", k), pk2, t2_pk[k]);
        check($sformatf("s2_tr%0d", k), tr2, t2_tr[k]);
      end
    end

    // one-shot
    do_reset();
    mode_s = 2'b10;
    for (int k = 0; k < 10; k++) begin
      adv(1'b1);
      check($sformatf("os_cnt%0d", k), cnt0, t3_cnt[k]);
      check($sformatf("os_done%0d", k), dn0, (k == 9) ? 1 : 0);
    end
    check("os_trough", tr0, 1);
    for (int k = 0; k < 2; k++) begin
      adv(1'b1);
      check($sformatf("os_hold_cnt%0d", k), cnt0, 0);
      check($sformatf("os_hold_done%0d", k), dn0, 1);
      check($sformatf("os_hold_tr%0d", k), tr0, 0);
    end
    restart_s = 1'b1;
    adv(1'b0);
    restart_s = 1'b0;
    check("os_rs_done", dn0, 0);
    check("os_rs_cnt", cnt0, 0);
    check("os_rs_dir", dir0, 1);
    adv(1'b1);
    check("os_after_cnt", cnt0, 1);

    // sawtooth
    do_reset();
    mode_s = 2'b01;
    for (int k = 0; k < 7; k++) begin
      adv(1'b1);
      check($sformatf("saw_cnt%0d", k), cnt0, t4_cnt[k]);
      check($sformatf("saw_pk%0d", k), pk0, t4_pk[k]);
      check($sformatf("saw_tr%0d", k), tr0, t4_tr[k]);
      check($sformatf("saw_dir%0d", k), dir0, 1);
    end

    // async reset mid-descent
    do_reset();
    mode_s = 2'b00;
    for (int k = 0; k < 7; k++) adv(1'b1);
    check("ar_pre_cnt", cnt0, 3);
    check("ar_pre_dir", dir0, 0);
    in_s = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("ar_cnt", cnt0, 0);
    check("ar_dir", dir0, 1);
    check("ar_peak", pk0, 0);
    check("ar_trough", tr0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // hold on in=0, restart beats in
    adv(1'b1);
    check("hold_a", cnt0, 1);
    adv(1'b0);
    check("hold_b", cnt0, 1);
    adv(1'b1);
    check("hold_c", cnt0, 2);
    adv(1'b0);
    check("hold_d", cnt0, 2);
    check("hold_pk", pk0, 0);
    restart_s = 1'b1;
    adv(1'b1);
    restart_s = 1'b0;
    check("rs_in_cnt", cnt0, 0);
    check("rs_in_dir", dir0, 1);
    for (int k = 0; k < 20; k++) adv(1'b1);
    check("two_tri_cnt", cnt0, 0);
    check("two_tri_tr", tr0, 1);
`ifdef TRI_PERIOD_CNT_EN
    check("two_tri_pcnt", pc0, 2);
`endif
    in_s = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
